// File: rtl/dmem_if.sv
// Memory-stage request/response bundle between the core (master) and a data-memory responder (slave).
interface dmem_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_byte, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_byte, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: big-endian 16-bit word store with byte/word access,
// fixed modelled access latency and a held response until the core consumes it.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output logic   busy
);

  localparam int         WORDS    = 2 ** (ADDR_W - 1);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       mem_q [WORDS];

  logic              accept;
  logic              commit;
  logic              op_wr;
  logic              op_byte;
  logic [ADDR_W-1:0] op_addr;
  logic [15:0]       op_wdata;
  logic [ADDR_W-2:0] mem_idx;
  logic [15:0]       mem_old;
  logic              misal;
  logic              mem_we;
  logic [15:0]       mem_wdata;

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With no wait cycles the commit edge is the accept edge, so operands come straight from the bus
  always_comb begin
    wr_d    = accept ? bus.req_wr    : wr_q;
    byte_d  = accept ? bus.req_byte  : byte_q;
    addr_d  = accept ? bus.req_addr  : addr_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;

    op_wr    = (state_q == S_IDLE) ? bus.req_wr    : wr_q;
    op_byte  = (state_q == S_IDLE) ? bus.req_byte  : byte_q;
    op_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
    op_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
  end

  // Access is performed on the edge that enters RESP
  always_comb begin
    commit    = (state_d == S_RESP) && (state_q != S_RESP);
    mem_idx   = op_addr[ADDR_W-1:1];
    mem_old   = mem_q[mem_idx];
    misal     = !op_byte && op_addr[0];
    mem_we    = 1'b0;
    mem_wdata = mem_old;
    rdata_d   = rdata_q;
    err_d     = err_q;
    if (commit) begin
      err_d   = misal;
      rdata_d = 16'h0000;
      if (!misal) begin
        if (op_wr) begin
          mem_we = 1'b1;
          if (!op_byte)
            mem_wdata = op_wdata;
          else if (op_addr[0])
            mem_wdata = {mem_old[15:8], op_wdata[7:0]};
          else
            mem_wdata = {op_wdata[7:0], mem_old[7:0]};
        end else if (op_byte) begin
          rdata_d = {8'h00, (op_addr[0] ? mem_old[7:0] : mem_old[15:8])};
        end else begin
          rdata_d = mem_old;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    busy          = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      for (int i = 0; i < WORDS; i++) mem_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end
  end

  // Latched request operands carry no reset; they are only read after an accept
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    byte_q  <= byte_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule
